// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-addressed data RAM: one request in flight,
// byte-lane stores, aligned and extended loads, error response for bad requests.
module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 28672
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wenable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RDWAIT, RESP} state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

  state_t      state_reg, state_next;
  logic [31:0] index_reg;
  logic [31:0] rdata_reg;
  logic        error_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;

  logic [31:0] offset;
  logic        fault;
  logic        fire;
  logic        store_fire;
  logic [3:0]  lane_sel;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign offset = req_addr - BASE_ADDR;

  // Wrap-around of the subtraction is caught by the explicit below-base test.
  assign fault = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (req_addr < BASE_ADDR)
              || (offset >= LIMIT);

  assign req_ready  = (state_reg == IDLE) && resetn;
  assign fire       = req_valid && req_ready;
  assign store_fire = fire && !fault && req_write;

  assign mem_addr  = (state_reg == IDLE) ? {2'b00, offset[31:2]} : index_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_error = error_reg;

  always_comb begin
    lane_sel  = 4'b0000;
    mem_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        lane_sel  = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_sel  = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
      end
      2'b10:   lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_wenable[gi] = store_fire && lane_sel[gi];
    end
  endgenerate

  always_comb begin
    byte_sel  = mem_rdata[8*off_reg +: 8];
    half_sel  = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (size_reg)
      2'b00:   load_data = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_reg & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (fire) state_next = (fault || req_write) ? RESP : RDWAIT;
      end
      RDWAIT:  state_next = RESP;
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= IDLE;
      index_reg <= 32'h0;
      rdata_reg <= 32'h0;
      error_reg <= 1'b0;
      off_reg   <= 2'b00;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (fire) begin
            index_reg <= {2'b00, offset[31:2]};
            off_reg   <= req_addr[1:0];
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            rdata_reg <= 32'h0;
            error_reg <= fault;
          end
        end
        RDWAIT: begin
          rdata_reg <= load_data;
          error_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural one-cycle-read RAM attached.
module tb_dmem_lsu;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 28672;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  logic        obs_ready;
  logic [31:0] obs_addr;
  logic [3:0]  obs_wen;
  logic [31:0] obs_wdata;
  logic [3:0]  wen_seen;
  int          lat;
  logic [31:0] got_rdata;
  logic        got_err;

  dmem_lsu #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .mem_addr(mem_addr),
    .mem_wenable(mem_wenable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // External RAM: byte-lane writes, registered read of the old word.
  logic [31:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_addr < 32'(DEPTH)) begin
      for (int b = 0; b < 4; b++)
        if (mem_wenable[b]) ram[mem_addr[14:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[14:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one request, records handshake-cycle outputs, then waits (bounded)
  // for the response; leaves the bench at the negedge of the response cycle.
  task automatic transact(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    #1;
    obs_ready = req_ready; obs_addr = mem_addr; obs_wen = mem_wenable; obs_wdata = mem_wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1; wen_seen = 4'b0;
    @(negedge clock);
    while (!rsp_valid && lat < 8) begin
      wen_seen |= mem_wenable;
      lat++;
      @(negedge clock);
    end
    got_rdata = rsp_rdata; got_err = rsp_error;
    $display("txn w=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
             w, sz, u, a, d, lat, got_rdata, got_err);
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", rsp_valid); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else passed++;
    total++; if (mem_wenable !== 4'b0) $display("FAIL rst_wen got=%b exp=0000", mem_wenable); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); else passed++;
    total++; if (rsp_error !== 1'b0) $display("FAIL rst_error got=%b exp=0", rsp_error); else passed++;
    req_valid = 1'b0; resetn = 1'b1;
    @(negedge clock);
    total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", req_ready); else passed++;
  endtask

  task automatic test_word();
    transact(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hDEADBEEF);
    total++; if (obs_ready !== 1'b1) $display("FAIL sw_ready got=%b exp=1", obs_ready); else passed++;
    total++; if (obs_addr !== 32'd4) $display("FAIL sw_addr got=%h exp=4", obs_addr); else passed++;
    total++; if (obs_wen !== 4'b1111) $display("FAIL sw_wen got=%b exp=1111", obs_wen); else passed++;
    total++; if (obs_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got=%h exp=deadbeef", obs_wdata); else passed++;
    total++; if (lat !== 1) $display("FAIL sw_lat got=%0d exp=1", lat); else passed++;
    total++; if ({got_err, got_rdata} !== 33'h0) $display("FAIL sw_rsp got=%b/%h exp=0/0", got_err, got_rdata); else passed++;
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
    total++; if (obs_wen !== 4'b0) $display("FAIL lw_wen got=%b exp=0000", obs_wen); else passed++;
    total++; if (lat !== 2) $display("FAIL lw_lat got=%0d exp=2", lat); else passed++;
    total++; if (got_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", got_rdata); else passed++;
    total++; if (got_err !== 1'b0) $display("FAIL lw_err got=%b exp=0", got_err); else passed++;
  endtask

  task automatic test_byte();
    transact(1'b1, 2'b00, 1'b0, BASE + 32'h13, 32'h0000_0080);
    total++; if (obs_wen !== 4'b1000) $display("FAIL sb_wen got=%b exp=1000", obs_wen); else passed++;
    total++; if (obs_wdata !== 32'h80808080) $display("FAIL sb_wdata got=%h exp=80808080", obs_wdata); else passed++;
    transact(1'b0, 2'b00, 1'b0, BASE + 32'h13, 32'h0);
    total++; if (got_rdata !== 32'hFFFFFF80) $display("FAIL lb_signed got=%h exp=ffffff80", got_rdata); else passed++;
    transact(1'b0, 2'b00, 1'b1, BASE + 32'h13, 32'h0);
    total++; if (got_rdata !== 32'h00000080) $display("FAIL lb_unsigned got=%h exp=00000080", got_rdata); else passed++;
    transact(1'b0, 2'b00, 1'b1, BASE + 32'h11, 32'h0);
    total++; if (got_rdata !== 32'h000000BE) $display("FAIL lbu_lane1 got=%h exp=000000be", got_rdata); else passed++;
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
    total++; if (got_rdata !== 32'h80ADBEEF) $display("FAIL lw_merged got=%h exp=80adbeef", got_rdata); else passed++;
  endtask

  task automatic test_half();
    transact(1'b1, 2'b01, 1'b0, BASE + 32'h12, 32'hAAAA_1234);
    total++; if (obs_wen !== 4'b1100) $display("FAIL sh_wen got=%b exp=1100", obs_wen); else passed++;
    total++; if (obs_wdata !== 32'h12341234) $display("FAIL sh_wdata got=%h exp=12341234", obs_wdata); else passed++;
    transact(1'b0, 2'b01, 1'b0, BASE + 32'h12, 32'h0);
    total++; if (got_rdata !== 32'h00001234) $display("FAIL lh_hi got=%h exp=00001234", got_rdata); else passed++;
    transact(1'b0, 2'b01, 1'b0, BASE + 32'h10, 32'h0);
    total++; if (got_rdata !== 32'hFFFFBEEF) $display("FAIL lh_lo_signed got=%h exp=ffffbeef", got_rdata); else passed++;
  endtask

  task automatic test_faults();
    logic        fw [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  fs [4]  = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] fa [4]  = '{BASE + 32'h2, BASE + 32'h1, BASE + 32'h0, BASE + 32'(DEPTH * 4)};
    for (int i = 0; i < 4; i++) begin
      transact(fw[i], fs[i], 1'b0, fa[i], 32'hFFFF_FFFF);
      total++; if (got_err !== 1'b1) $display("FAIL fault%0d_err got=%b exp=1", i, got_err); else passed++;
      total++; if (got_rdata !== 32'h0) $display("FAIL fault%0d_rdata got=%h exp=0", i, got_rdata); else passed++;
      total++; if (lat !== 1) $display("FAIL fault%0d_lat got=%0d exp=1", i, lat); else passed++;
      total++; if ((obs_wen | wen_seen) !== 4'b0) $display("FAIL fault%0d_wen got=%b exp=0000", i, obs_wen | wen_seen); else passed++;
    end
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h0, 32'h0);
    total++; if (got_err !== 1'b0) $display("FAIL fault_clear_err got=%b exp=0", got_err); else passed++;
  endtask

  task automatic test_back_to_back();
    transact(1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'h0BAD_F00D);
    @(negedge clock);
    total++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL b2b_store got=%b exp=10", {req_ready, rsp_valid}); else passed++;
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0);
    total++; if (got_rdata !== 32'h0BADF00D) $display("FAIL b2b_load_rdata got=%h exp=0badf00d", got_rdata); else passed++;
    @(negedge clock);
    total++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL b2b_load got=%b exp=10", {req_ready, rsp_valid}); else passed++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
    total++; if (got_rdata !== 32'h1234BEEF) $display("FAIL bp_rdata got=%h exp=1234beef", got_rdata); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total++;
      if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'h1234BEEF)
        $display("FAIL bp_hold%0d got=%b%b/%h exp=10/1234beef", c, rsp_valid, req_ready, rsp_rdata);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    total++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL bp_release got=%b exp=01", {rsp_valid, req_ready}); else passed++;
  endtask

  task automatic test_reset_midload();
    logic seen;
    transact(1'b1, 2'b10, 1'b0, BASE + 32'h20, 32'hCAFEF00D);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = BASE + 32'h20;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    total++; if ({rsp_valid, req_ready} !== 2'b00) $display("FAIL rml_reset got=%b exp=00", {rsp_valid, req_ready}); else passed++;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      seen |= rsp_valid;
    end
    total++; if (seen !== 1'b0) $display("FAIL rml_no_rsp got=%b exp=0", seen); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rml_idle got=%b exp=1", req_ready); else passed++;
    transact(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0);
    total++; if (got_rdata !== 32'hCAFEF00D) $display("FAIL rml_intact got=%h exp=cafef00d", got_rdata); else passed++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_backpressure();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator between the core's memory request port and the word-addressed data RAM (`dmem`). Accepts one byte, halfword or word load/store per handshake from a byte address. Converts it into a word index, byte-lane write enables and lane-replicated write data. Collects the RAM's one-cycle-late read word and returns an aligned, sign- or zero-extended result. Misaligned, illegal-size and out-of-range requests are rejected with an error response and never touch the RAM.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of RAM word 0
- `DEPTH`, 28672: RAM size in 32-bit words
- `clock` in 1: single clock, all state on rising edge
- `resetn` in 1: synchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when high with `req_valid`
- `req_write` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, LSB-aligned
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed when high with `rsp_valid`
- `rsp_rdata` out 32: load result, 0 for stores and errors
- `rsp_error` out 1: request was rejected
- `mem_addr` out 32: word index to RAM, `(req_addr - BASE_ADDR) >> 2`
- `mem_wenable` out 4: byte-lane write enables to RAM
- `mem_wdata` out 32: write data to RAM
- `mem_rdata` in 32: RAM read word, valid one cycle after `mem_addr` is sampled

## Operation
- States: IDLE, RDWAIT, RESP. The reset state is IDLE.
- `req_ready` = 1 only in IDLE while `resetn` is high. A handshake occurs when `req_valid & req_ready`.
- Fault is evaluated combinationally in IDLE and is true for any of:
  - `req_size`=11
  - half with `req_addr[0]`=1
  - word with `req_addr[1:0]`≠0
  - `req_addr` < `BASE_ADDR`
  - `req_addr - BASE_ADDR` ≥ `DEPTH*4` (32-bit unsigned compare)
- `mem_addr` is driven combinationally from `req_addr` in IDLE. It holds the last accepted index in other states.
- `mem_wenable` is nonzero only in the handshake cycle of a non-faulting store with `resetn` high. Otherwise it is 4'b0000.
- Store lanes, where `o` = `req_addr[1:0]`:
  - byte: `mem_wenable` = 1<<o, `mem_wdata` = `{4{wdata[7:0]}}`
  - half: `mem_wenable` = 0011 or 1100 (selected by `o[1]`), `mem_wdata` = `{2{wdata[15:0]}}`
  - word: `mem_wenable` = 1111, `mem_wdata` = `wdata`
- Transitions from IDLE on handshake:
  - faulting request → RESP with `rsp_error`=1, `rsp_rdata`=0
  - non-faulting store → RESP with `rsp_error`=0, `rsp_rdata`=0
  - non-faulting load → RDWAIT; registered `o`, `req_size` and `req_unsigned` are kept
- RDWAIT: extract from `mem_rdata` and go to RESP.
  - byte: lane `o`
  - half: lane pair `o[1]`
  - word: full word
  - extend bit 7 or bit 15 unless `req_unsigned`
  - register the result into `rsp_rdata`
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_error` stay stable until `rsp_ready`, then go to IDLE. `rsp_valid` drops the next cycle.
- Only one request is outstanding. No new request is accepted while RDWAIT or RESP.

## Timing
- Reset (`resetn` low at an edge) sets: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0.
- While `resetn` is low, `req_ready`=0 and `mem_wenable`=0.
- Let T be the handshake cycle. The RAM captures the address and write at the end of T.
- Store or error response: `rsp_valid`=1 in T+1.
- Load response: `rsp_valid`=1 in T+2, because `mem_rdata` is sampled in T+1.
- `rsp_ready` held high: the next `req_ready` is in T+2 for stores and errors, T+3 for loads.
- `rsp_ready` low: the state stays in RESP indefinitely with outputs frozen.
- Reset mid-operation: a store already committed in T stays in memory. A pending load or response is discarded, and no `rsp_valid` is produced after reset.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Word store then load: store 0xDEADBEEF @BASE+0x10, then load word @BASE+0x10.
  - store handshake cycle: `mem_addr`=4, `mem_wenable`=1111
  - store response at T+1
  - load response at T+2 with `rsp_rdata`=0xDEADBEEF
- Byte store 0x80 @BASE+0x13 → `mem_wenable`=1000.
  - load byte signed → 0xFFFFFF80
  - load byte unsigned → 0x00000080
  - load word → 0x80ADBEEF
- Half store 0x1234 @BASE+0x12 → `mem_wenable`=1100. Load half signed @BASE+0x12 → 0x00001234.
- Faults, each giving an error response at T+1 with `rsp_rdata`=0 and `mem_wenable`=0 throughout:
  - word load @BASE+0x2
  - half store @BASE+0x1
  - `req_size`=11
  - load @BASE+DEPTH*4
- Backpressure: keep `rsp_ready` low for 5 cycles after a load response.
  - `rsp_valid` and `rsp_rdata` stay stable
  - `req_ready` stays 0
  - after `rsp_ready`, `rsp_valid` drops and `req_ready` rises the next cycle
- Reset mid-load: assert `resetn` low in RDWAIT.
  - next cycle: state IDLE, `rsp_valid`=0
  - a memory word stored before the reset reads back intact
